// File: rtl/alu_wake_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_wake_ctrl
// Purpose  : Power/clock-enable controller for the adaptive ALU. Wakes the
//            ALU on demand (execute arithmetic op) or predictively from the
//            hint FIFO, and returns it to sleep after a programmable idle
//            timeout.
// Options  : `define PRED_WAKE_EN enables hint-driven wake, counts fifo_valid
//            as activity and adds the pred_wake_count output.
// Revision : 1.0 - initial release
// ============================================================================
module alu_wake_ctrl #(
  parameter int DEPTH        = 4,
  parameter int WAKE_CYCLES  = 3,
  parameter int IDLE_TIMEOUT = 8,
  parameter int HINT_THRESH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] fifo_bits,
  input  logic             fifo_valid,
  input  logic             ex_arith_req,
  output logic             alu_en,
  output logic             alu_ready,
  output logic             stall_req,
  output logic [1:0]       state_o,
  output logic [15:0]      wake_count
`ifdef PRED_WAKE_EN
  ,
  output logic [15:0]      pred_wake_count
`endif
);

  typedef enum logic [1:0] {
    ST_SLEEP  = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Counter reload values; WAKE counts down to zero so it lasts WAKE_CYCLES.
  localparam logic [3:0]  c_WAKE_LOAD = 4'(WAKE_CYCLES - 1);
  localparam logic [7:0]  c_IDLE_LOAD = 8'(IDLE_TIMEOUT);
  localparam logic [15:0] c_SAT       = 16'hFFFF;

  state_t      r_state;
  logic [3:0]  r_wake_cnt;
  logic [7:0]  r_idle_cnt;
  logic [15:0] r_wake_count;
  logic        r_alu_en;
  logic        r_alu_ready;

  logic        w_wake_trig;
  logic        w_activity;

`ifdef PRED_WAKE_EN
  logic [31:0] w_popcnt;
  logic        w_hint_hit;
  logic [15:0] r_pred_wake_count;

  // Population count of the hint vector.
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_popcnt = w_popcnt + {31'd0, fifo_bits[i]};
    end
  end

  assign w_hint_hit  = fifo_valid & (w_popcnt >= 32'(HINT_THRESH));
  assign w_wake_trig = ex_arith_req | w_hint_hit;
  assign w_activity  = ex_arith_req | fifo_valid;
  assign pred_wake_count = r_pred_wake_count;
`else
  // Hint inputs are intentionally ignored in this build.
  logic w_unused_hint;
  assign w_unused_hint = ^{fifo_bits, fifo_valid};
  assign w_wake_trig   = ex_arith_req;
  assign w_activity    = ex_arith_req;
`endif

  // Sleep/wake state machine with counters and registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_SLEEP;
      r_wake_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_wake_count <= '0;
      r_alu_en     <= 1'b0;
      r_alu_ready  <= 1'b0;
`ifdef PRED_WAKE_EN
      r_pred_wake_count <= '0;
`endif
    end else begin
      case (r_state)
        ST_SLEEP: begin
          if (w_wake_trig) begin
            r_state    <= ST_WAKE;
            r_alu_en   <= 1'b1;
            r_wake_cnt <= c_WAKE_LOAD;
            if (r_wake_count != c_SAT) begin
              r_wake_count <= r_wake_count + 16'd1;
            end
`ifdef PRED_WAKE_EN
            // Credit the wake to the predictor only when execute did not ask.
            if (!ex_arith_req && (r_pred_wake_count != c_SAT)) begin
              r_pred_wake_count <= r_pred_wake_count + 16'd1;
            end
`endif
          end
        end
        ST_WAKE: begin
          if (r_wake_cnt == 4'd0) begin
            r_state     <= ST_ACTIVE;
            r_alu_ready <= 1'b1;
            r_idle_cnt  <= c_IDLE_LOAD;
          end else begin
            r_wake_cnt <= r_wake_cnt - 4'd1;
          end
        end
        ST_ACTIVE: begin
          if (w_activity) begin
            r_idle_cnt <= c_IDLE_LOAD;
          end else if (r_idle_cnt <= 8'd1) begin
            // Last inactive cycle of the timeout; the <= guards underflow.
            r_state <= ST_DRAIN;
          end else begin
            r_idle_cnt <= r_idle_cnt - 8'd1;
          end
        end
        default: begin
          // DRAIN: ALU still powered, one chance to be rescued by activity.
          if (w_activity) begin
            r_state    <= ST_ACTIVE;
            r_idle_cnt <= c_IDLE_LOAD;
          end else begin
            r_state     <= ST_SLEEP;
            r_alu_en    <= 1'b0;
            r_alu_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  assign alu_en     = r_alu_en;
  assign alu_ready  = r_alu_ready;
  assign state_o    = r_state;
  assign wake_count = r_wake_count;
  assign stall_req  = ex_arith_req & ~r_alu_ready;

endmodule
`default_nettype wire

// File: tb/tb_alu_wake_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_wake_ctrl
// Purpose  : Self-checking bench for alu_wake_ctrl: table vectors, directed
//            corner sequences and randomized traffic against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_wake_ctrl;
  localparam int DEPTH        = 4;
  localparam int WAKE_CYCLES  = 3;
  localparam int IDLE_TIMEOUT = 8;
  localparam int HINT_THRESH  = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [DEPTH-1:0] fifo_bits;
  logic             fifo_valid;
  logic             ex_arith_req;
  logic             alu_en;
  logic             alu_ready;
  logic             stall_req;
  logic [1:0]       state_o;
  logic [15:0]      wake_count;
`ifdef PRED_WAKE_EN
  logic [15:0]      pred_wake_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_wake_ctrl #(
    .DEPTH(DEPTH), .WAKE_CYCLES(WAKE_CYCLES),
    .IDLE_TIMEOUT(IDLE_TIMEOUT), .HINT_THRESH(HINT_THRESH)
  ) dut (
    .clk(clk), .rst(rst), .fifo_bits(fifo_bits), .fifo_valid(fifo_valid),
    .ex_arith_req(ex_arith_req), .alu_en(alu_en), .alu_ready(alu_ready),
    .stall_req(stall_req), .state_o(state_o), .wake_count(wake_count)
`ifdef PRED_WAKE_EN
    , .pred_wake_count(pred_wake_count)
`endif
  );

  // Reference model: phase plus up-counting ages, per the behavioural rules.
  int m_state;    // 0 sleep, 1 wake, 2 active, 3 drain
  int m_age;      // cycles spent in WAKE so far
  int m_inact;    // consecutive inactive ACTIVE cycles
  int m_wakes;
  int m_pwakes;

  typedef struct {
    logic        req;
    logic [1:0]  st;
    logic        stall;
    logic        ready;
    logic        en;
    logic [15:0] wc;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return {11'd0, alu_en, alu_ready, stall_req, state_o, wake_count};
  endfunction

  task automatic model_reset();
    m_state = 0; m_age = 0; m_inact = 0; m_wakes = 0; m_pwakes = 0;
  endtask

  task automatic model_step(input logic req, input logic fv, input logic [DEPTH-1:0] fb);
    bit hint, act, trig;
`ifdef PRED_WAKE_EN
    hint = fv && ($countones(fb) >= HINT_THRESH);
    act  = req || fv;
`else
    hint = 1'b0;
    act  = req;
`endif
    trig = req || hint;
    case (m_state)
      0: if (trig) begin
           m_state = 1; m_age = 0;
           if (m_wakes < 65535) m_wakes++;
           if (!req && m_pwakes < 65535) m_pwakes++;
         end
      1: begin
           m_age++;
           if (m_age == WAKE_CYCLES) begin m_state = 2; m_inact = 0; end
         end
      2: if (act) m_inact = 0;
         else begin
           m_inact++;
           if (m_inact == IDLE_TIMEOUT) m_state = 3;
         end
      default: if (act) begin m_state = 2; m_inact = 0; end
               else m_state = 0;
    endcase
  endtask

  task automatic check_model(input string name);
    logic en, rdy;
    en  = (m_state != 0);
    rdy = (m_state >= 2);
    check(name, pack_out(),
          {11'd0, en, rdy, ex_arith_req & ~rdy, 2'(m_state), 16'(m_wakes)});
`ifdef PRED_WAKE_EN
    check({name, "_pred"}, 32'(pred_wake_count), 32'(m_pwakes));
`endif
  endtask

  task automatic drive(input logic req, input logic fv, input logic [DEPTH-1:0] fb);
    @(negedge clk);
    ex_arith_req = req; fifo_valid = fv; fifo_bits = fb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(ex_arith_req, fifo_valid, fifo_bits);
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic async_reset(input string name);
    @(negedge clk);
    ex_arith_req = 1'b0; fifo_valid = 1'b0; fifo_bits = '0;
    #1 rst = 1'b1;
    #1 check(name, pack_out(), 32'd0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int density;
    rst = 1'b1; ex_arith_req = 1'b0; fifo_valid = 1'b0; fifo_bits = '0;
    model_reset();

    // Demand wake, timeout, DRAIN rescue, second timeout back to SLEEP.
    tbl.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 16'd0});
    for (int i = 1; i <= 3; i++) tbl.push_back('{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 16'd1});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 16'd1});
    for (int i = 5; i <= 12; i++) tbl.push_back('{1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 16'd1});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 16'd1});
    for (int i = 14; i <= 21; i++) tbl.push_back('{1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 16'd1});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 16'd1});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1});

    #12;
    check("reset_hold", pack_out(), 32'd0);
    @(negedge clk); #2 rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].req, 1'b0, '0);
      check($sformatf("vec%0d", i), pack_out(),
            {11'd0, tbl[i].en, tbl[i].ready, tbl[i].stall, tbl[i].st, tbl[i].wc});
      tick();
    end

    async_reset("reset_after_table");

`ifdef PRED_WAKE_EN
    // One-cycle hint wakes predictively; demand at cycle 4 sees no stall.
    drive(1'b0, 1'b1, 4'b0001);
    check("hint_c0_state", 32'(state_o), 32'd0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 1'b0, '0);
      check($sformatf("hint_c%0d_state", c), 32'(state_o), 32'd1);
      tick();
    end
    drive(1'b1, 1'b0, '0);
    check("hint_c4_state", 32'(state_o), 32'd2);
    check("hint_c4_stall", 32'(stall_req), 32'd0);
    tick();
    check("hint_pred_count", 32'(pred_wake_count), 32'd1);
    check("hint_wake_count", 32'(wake_count), 32'd1);
`else
    // Hints are ignored: a saturated hint vector never wakes the ALU.
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b1, 4'b1111);
      check($sformatf("nohint_c%0d", c), {30'd0, state_o}, 32'd0);
      tick();
    end
    check("nohint_wake_count", 32'(wake_count), 32'd0);
`endif

    // Reset while in WAKE drops alu_en without a clock edge.
    async_reset("reset_pre_wake");
    drive(1'b1, 1'b0, '0); tick();
    drive(1'b1, 1'b0, '0);
    check("in_wake_state", 32'(state_o), 32'd1);
    tick();
    async_reset("reset_mid_wake");

    // Randomized traffic with varying activity density against the model.
    for (int blk = 0; blk < 30; blk++) begin
      density = int'($urandom_range(1, 5));
      for (int c = 0; c < 100; c++) begin
        drive(($urandom_range(0, 15) < density),
              ($urandom_range(0, 15) < density),
              DEPTH'($urandom));
        check_model($sformatf("rand_b%0d_c%0d", blk, c));
        tick();
      end
      if (blk % 7 == 6) async_reset($sformatf("rand_reset_b%0d", blk));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_wake_ctrl.md
Name: alu_wake_ctrl

Overview:
Power/clock-enable controller for the adaptive ALU. It sits directly downstream of the fetch-stage arithmetic-hint FIFO and consumes that FIFO's hint vector and valid flag. It wakes the ALU predictively when upcoming arithmetic is hinted, wakes it on demand when execute presents an arithmetic op, and puts it back to sleep after a programmable idle timeout.

Parameters:
DEPTH, 4, width of the incoming hint vector; must match the hint FIFO depth.
WAKE_CYCLES, 3, ALU power-up latency in cycles; range 1..15.
IDLE_TIMEOUT, 8, consecutive inactive cycles in ACTIVE before entering DRAIN; range 1..255.
HINT_THRESH, 1, minimum popcount of fifo_bits that triggers a predictive wake; range 1..DEPTH.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
fifo_bits  input  DEPTH  arithmetic-hint vector from the hint FIFO
fifo_valid  input  1  hint FIFO holds at least one set hint
ex_arith_req  input  1  execute stage has an arithmetic op this cycle
alu_en  output  1  ALU power/clock enable
alu_ready  output  1  ALU usable this cycle
stall_req  output  1  pipeline stall request to execute
state_o  output  2  current state: SLEEP=0, WAKE=1, ACTIVE=2, DRAIN=3
wake_count  output  16  number of SLEEP->WAKE transitions, saturating

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (asynchronous, takes effect immediately even mid-WAKE or mid-ACTIVE):
  - state = SLEEP; wake_cnt, idle_cnt and wake_count = 0.
  - alu_en = 0, alu_ready = 0, stall_req = 0, state_o = 0.
- Output decoding:
  - alu_en, alu_ready and state_o are Moore outputs decoded from the state register only.
  - alu_en = 1 in WAKE, ACTIVE and DRAIN.
  - alu_ready = 1 in ACTIVE and DRAIN.
  - stall_req = ex_arith_req & ~alu_ready (combinational).
- Wake trigger: hint_hit = fifo_valid & (popcount(fifo_bits) >= HINT_THRESH).
- SLEEP:
  - If ex_arith_req | hint_hit, go to WAKE and load wake_cnt = WAKE_CYCLES-1.
  - wake_count increments once per transition, saturating at 16'hFFFF.
  - Demand and hint in the same cycle produce one wake and one count.
- WAKE:
  - If wake_cnt == 0, go to ACTIVE and load idle_cnt = IDLE_TIMEOUT. Otherwise decrement wake_cnt.
  - WAKE lasts exactly WAKE_CYCLES cycles. Inputs are ignored except for stall_req.
- ACTIVE:
  - activity = ex_arith_req | fifo_valid.
  - On activity, reload idle_cnt = IDLE_TIMEOUT.
  - Otherwise, if idle_cnt == 1 go to DRAIN, else decrement idle_cnt.
  - Net effect: exactly IDLE_TIMEOUT consecutive inactive cycles give DRAIN on the following cycle.
- DRAIN (one cycle; ALU still powered):
  - If activity, return to ACTIVE and reload idle_cnt. No stall; wake_count unchanged.
  - Otherwise go to SLEEP.
- Demand-wake latency: a request first seen in SLEEP at cycle t sees alu_ready = 1 at cycle t+WAKE_CYCLES+1. stall_req is high for WAKE_CYCLES+1 cycles if the request is held.
- Counter widths: wake_cnt is 4 bits, idle_cnt is 8 bits. Neither counter ever underflows.

Optional Feature:
Macro PRED_WAKE_EN.
- Defined:
  - hint_hit triggers wake from SLEEP.
  - fifo_valid counts as activity in ACTIVE and DRAIN.
  - Adds output pred_wake_count (16 bits, saturating), which increments on SLEEP->WAKE transitions caused by hint_hit alone (ex_arith_req low).
- Undefined:
  - fifo_bits and fifo_valid are ignored.
  - Only ex_arith_req wakes the ALU or counts as activity.
  - pred_wake_count port is absent.

Test Plan:
1. Assert rst mid-stream, then release -> alu_en = 0, alu_ready = 0, stall_req = 0, state_o = 0, wake_count = 0 with no clock edge required.
2. Demand wake, WAKE_CYCLES=3: ex_arith_req held high from cycle 0 in SLEEP -> stall_req high for cycles 0-3; alu_ready = 1 and stall_req = 0 at cycle 4; wake_count = 1.
3. PRED_WAKE_EN defined, fifo_bits = 4'b0001, fifo_valid = 1 for one cycle in SLEEP; ex_arith_req pulse at cycle 4 -> state_o = 1 at cycle 1, ACTIVE at cycle 4, stall_req never asserted; pred_wake_count = 1.
4. Idle timeout, IDLE_TIMEOUT=8: enter ACTIVE with all inputs low -> state_o = 3 after 8 inactive cycles, SLEEP on the next cycle with alu_en = 0.
5. DRAIN rescue: ex_arith_req = 1 during the DRAIN cycle -> state_o = 2 next cycle, stall_req = 0, wake_count unchanged; idle_cnt reloads so a fresh 8-cycle timeout applies.
6. PRED_WAKE_EN undefined, fifo_bits = 4'b1111, fifo_valid = 1 held in SLEEP for 20 cycles -> state stays SLEEP, wake_count = 0; then assert rst while in WAKE -> alu_en drops asynchronously.
